// File: rtl/execute_stage_mc_if.sv
// ---------------------------------------------------------------------------
// execute_stage_mc_if
// Bundles the ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   master : the pipeline around the stage (drives E-stage inputs, reads M outputs)
//   slave  : the execute stage itself
// Signals:
//   E inputs  : ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE,
//               ALUSrcE, ALUControlE[3:0], ShiftTypeE[1:0], ShiftAmountE[SHW],
//               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E[4:0], ResultW,
//               ForwardA_E[1:0], ForwardB_E[1:0]
//   E outputs : StallE, PCSrcE, PCTargetE, ALUFlagsE[3:0]
//   M outputs : ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M[4:0],
//               PCPlus4M, WriteDataM, ALU_ResultM
// ---------------------------------------------------------------------------
interface execute_stage_mc_if #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
);
    logic            ValidE;
    logic            FlushE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            BranchE;
    logic            ALUSrcE;
    logic [3:0]      ALUControlE;
    logic [1:0]      ShiftTypeE;
    logic [SHW-1:0]  ShiftAmountE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RD_E;
    logic [XLEN-1:0] ResultW;
    logic [1:0]      ForwardA_E;
    logic [1:0]      ForwardB_E;

    logic            StallE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic [3:0]      ALUFlagsE;

    logic            ValidM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] ALU_ResultM;

    modport master (
        output ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
               ALUControlE, ShiftTypeE, ShiftAmountE, RD1_E, RD2_E, Imm_Ext_E,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        input  StallE, PCSrcE, PCTargetE, ALUFlagsE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE,
               ALUControlE, ShiftTypeE, ShiftAmountE, RD1_E, RD2_E, Imm_Ext_E,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        output StallE, PCSrcE, PCTargetE, ALUFlagsE, ValidM, RegWriteM, MemWriteM,
               ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_stage_mc.sv
// ---------------------------------------------------------------------------
// execute_stage_mc
// Execute stage: operand forwarding, single-cycle ALU/shifter, branch
// resolution, iterative MUL/DIVU/REMU and the EX/MEM pipeline register.
// Ports:
//   clk         : pipeline clock
//   rst         : asynchronous reset, active-low
//   bus         : execute_stage_mc_if.slave (all E inputs / E and M outputs)
//   o_fsm_state : current multi-cycle FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Stall handshake: StallE=1 means the stage is occupied by a multi-cycle op;
// upstream must hold every E input stable, and the EX/MEM register receives a
// bubble. The op's result is presented in the single cycle with StallE=0 that
// follows (DONE) and is captured on that edge.
// ---------------------------------------------------------------------------
module execute_stage_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN),
    parameter int CW   = $clog2(XLEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    execute_stage_mc_if.slave  bus,
    output logic [1:0]         o_fsm_state
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    state_t          r_state;
    logic [XLEN-1:0] r_a;      // multiplicand / dividend-then-quotient
    logic [XLEN-1:0] r_b;      // multiplier / divisor
    logic [XLEN:0]   r_acc;    // product / partial remainder
    logic [3:0]      r_op;
    logic [CW-1:0]   r_cnt;

    logic [XLEN-1:0]   w_src_a, w_write_data, w_src_b;
    logic [XLEN:0]     w_sum, w_diff;
    logic [2*XLEN-1:0] w_rot;
    logic [XLEN-1:0]   w_shift, w_alu_result, w_mc_result, w_result;
    logic              w_is_mc, w_start, w_op_add, w_op_sub, w_c, w_v, w_m_valid;
    logic [XLEN:0]     w_rem_sh;
    logic              w_fits;

    function automatic logic [XLEN-1:0] fwd(input logic [XLEN-1:0] rf,
                                            input logic [1:0] sel,
                                            input logic [XLEN-1:0] res_w,
                                            input logic [XLEN-1:0] res_m);
        case (sel)
            2'b01:   fwd = res_w;
            2'b10:   fwd = res_m;
            default: fwd = rf;
        endcase
    endfunction

    assign w_src_a      = fwd(bus.RD1_E, bus.ForwardA_E, bus.ResultW, bus.ALU_ResultM);
    assign w_write_data = fwd(bus.RD2_E, bus.ForwardB_E, bus.ResultW, bus.ALU_ResultM);
    assign w_src_b      = bus.ALUSrcE ? bus.Imm_Ext_E : w_write_data;

    assign w_is_mc  = (bus.ALUControlE == OP_MUL) || (bus.ALUControlE == OP_DIVU) ||
                      (bus.ALUControlE == OP_REMU);
    assign w_start  = (r_state == ST_IDLE) && bus.ValidE && w_is_mc && !bus.FlushE;
    assign w_op_add = (bus.ALUControlE == 4'b0000) || (bus.ALUControlE >= 4'b1011);
    assign w_op_sub = (bus.ALUControlE == 4'b0001);

    // Reset forces StallE low even while a multi-cycle op is presented.
    assign bus.StallE = rst && (w_start || (r_state == ST_BUSY));

    always_comb begin
        w_sum   = {1'b0, w_src_a} + {1'b0, w_src_b};
        // a + ~b + 1: carry out set means no borrow
        w_diff  = {1'b0, w_src_a} + {1'b0, ~w_src_b} + {{XLEN{1'b0}}, 1'b1};
        w_rot   = {w_src_a, w_src_a} >> bus.ShiftAmountE;
        case (bus.ShiftTypeE)
            2'b00:   w_shift = w_src_a << bus.ShiftAmountE;
            2'b01:   w_shift = w_src_a >> bus.ShiftAmountE;
            2'b10:   w_shift = $signed(w_src_a) >>> bus.ShiftAmountE;
            default: w_shift = w_rot[XLEN-1:0];
        endcase
        case (bus.ALUControlE)
            4'b0001: w_alu_result = w_diff[XLEN-1:0];
            4'b0010: w_alu_result = w_src_a & w_src_b;
            4'b0011: w_alu_result = w_src_a | w_src_b;
            4'b0100: w_alu_result = w_src_a ^ w_src_b;
            4'b0101: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            4'b0110: w_alu_result = w_shift;
            4'b0111: w_alu_result = w_src_b;
            default: w_alu_result = w_sum[XLEN-1:0];
        endcase
    end

    // Restoring-division step: shift next dividend bit into the remainder.
    assign w_rem_sh = {r_acc[XLEN-1:0], r_a[XLEN-1]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_b});

    always_comb begin
        case (r_op)
            OP_MUL:  w_mc_result = r_acc[XLEN-1:0];
            OP_DIVU: w_mc_result = r_a;
            default: w_mc_result = r_acc[XLEN-1:0];
        endcase
    end

    assign w_result = (r_state == ST_DONE) ? w_mc_result : w_alu_result;

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (r_state != ST_DONE) begin
            if (w_op_add) begin
                w_c = w_sum[XLEN];
                w_v = (w_src_a[XLEN-1] == w_src_b[XLEN-1]) && (w_sum[XLEN-1] != w_src_a[XLEN-1]);
            end else if (w_op_sub) begin
                w_c = w_diff[XLEN];
                w_v = (w_src_a[XLEN-1] != w_src_b[XLEN-1]) && (w_diff[XLEN-1] != w_src_a[XLEN-1]);
            end
        end
    end

    assign bus.ALUFlagsE = {w_result[XLEN-1], (w_result == '0), w_c, w_v};
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = bus.BranchE && bus.ValidE && bus.ALUFlagsE[2] &&
                           !bus.FlushE && !bus.StallE;
    assign o_fsm_state   = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_a     <= w_src_a;
                        r_b     <= w_src_b;
                        r_acc   <= '0;
                        r_op    <= bus.ALUControlE;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.FlushE) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_op == OP_MUL) begin
                            r_acc <= {1'b0, r_acc[XLEN-1:0] + (r_b[0] ? r_a : '0)};
                            r_a   <= r_a << 1;
                            r_b   <= r_b >> 1;
                        end else begin
                            r_acc <= w_fits ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
                            r_a   <= {r_a[XLEN-2:0], w_fits};
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_m_valid = bus.ValidE && !bus.FlushE && !bus.StallE;

    // Data fields always load; only the control bits are forced to a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ValidM      <= 1'b0;
            bus.RegWriteM   <= 1'b0;
            bus.MemWriteM   <= 1'b0;
            bus.ResultSrcM  <= 1'b0;
            bus.RD_M        <= '0;
            bus.PCPlus4M    <= '0;
            bus.WriteDataM  <= '0;
            bus.ALU_ResultM <= '0;
        end else begin
            bus.ValidM      <= w_m_valid;
            bus.RegWriteM   <= bus.RegWriteE && w_m_valid;
            bus.MemWriteM   <= bus.MemWriteE && w_m_valid;
            bus.ResultSrcM  <= bus.ResultSrcE;
            bus.RD_M        <= bus.RD_E;
            bus.PCPlus4M    <= bus.PCPlus4E;
            bus.WriteDataM  <= w_write_data;
            bus.ALU_ResultM <= w_result;
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;
    localparam int XLEN = 32;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;
    int         n_tests;
    int         n_fail;

    execute_stage_mc_if #(.XLEN(XLEN)) bus ();

    execute_stage_mc #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [1:0] st,
                                               input logic [4:0] amt);
        logic [31:0] r;
        case (op)
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: begin
                r = a;
                for (int i = 0; i < int'(amt); i++) begin
                    case (st)
                        2'b00:   r = r << 1;
                        2'b01:   r = r >> 1;
                        2'b10:   r = {r[31], r[31:1]};
                        default: r = {r[0], r[31:1]};
                    endcase
                end
            end
            4'd7:  r = b;
            4'd8:  r = a * b;
            4'd9:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10: r = (b == 0) ? a : a % b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] res);
        longint s;
        logic   c, v;
        c = 1'b0;
        v = 1'b0;
        if (op == 4'd0 || op >= 4'd11) begin
            c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 4'd1) begin
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {res[31], (res == 32'd0), c, v};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ValidE = 0; bus.FlushE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0;
        bus.ResultSrcE = 0; bus.BranchE = 0; bus.ALUSrcE = 0; bus.ALUControlE = 0;
        bus.ShiftTypeE = 0; bus.ShiftAmountE = 0; bus.RD1_E = 0; bus.RD2_E = 0;
        bus.Imm_Ext_E = 0; bus.PCE = 0; bus.PCPlus4E = 0; bus.RD_E = 0;
        bus.ResultW = 0; bus.ForwardA_E = 0; bus.ForwardB_E = 0;
    endtask

    // Single-cycle op: A from RD1 (no forwarding), B from the immediate.
    task automatic apply_single(input string name, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [1:0] st, input logic [4:0] amt,
                                input logic [31:0] exp_res, input logic [3:0] exp_flags);
        idle_inputs();
        bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUSrcE = 1; bus.ALUControlE = op;
        bus.RD1_E = a; bus.Imm_Ext_E = b; bus.RD2_E = $urandom;
        bus.ShiftTypeE = st; bus.ShiftAmountE = amt;
        #1;
        check({name, "_flags"}, {28'd0, bus.ALUFlagsE}, {28'd0, exp_flags});
        step();
        check({name, "_res"}, bus.ALU_ResultM, exp_res);
        check({name, "_validm"}, {31'd0, bus.ValidM}, 32'd1);
    endtask

    // Multi-cycle op: operands from RD1/RD2, counts stall cycles, checks bubbles.
    task automatic run_mc(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        int stalls;
        idle_inputs();
        bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUControlE = op;
        bus.RD1_E = a; bus.RD2_E = b;
        #1;
        check({name, "_stall_start"}, {31'd0, bus.StallE}, 32'd1);
        stalls = 0;
        while (bus.StallE && stalls < 100) begin
            stalls++;
            step();
            check({name, "_bubble"}, {31'd0, bus.ValidM}, 32'd0);
        end
        check({name, "_stall_cycles"}, stalls, XLEN + 1);
        step();
        check({name, "_res"}, bus.ALU_ResultM, exp_res);
        check({name, "_validm"}, {31'd0, bus.ValidM}, 32'd1);
        check({name, "_regwm"}, {31'd0, bus.RegWriteM}, 32'd1);
        bus.ValidE = 0;
        bus.RegWriteE = 0;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  st;
        logic [4:0]  amt;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic [1:0]  st;
        logic [4:0]  amt;

        n_tests = 0;
        n_fail  = 0;

        vecs.push_back('{"add_small",  4'd0,  32'd1,          32'd2,          2'd0, 5'd0,  32'd3,          4'b0000});
        vecs.push_back('{"add_carry",  4'd0,  32'hFFFF_FFFF,  32'd1,          2'd0, 5'd0,  32'd0,          4'b0110});
        vecs.push_back('{"add_ovf",    4'd0,  32'h7FFF_FFFF,  32'd1,          2'd0, 5'd0,  32'h8000_0000,  4'b1001});
        vecs.push_back('{"sub_eq",     4'd1,  32'd5,          32'd5,          2'd0, 5'd0,  32'd0,          4'b0110});
        vecs.push_back('{"sub_borrow", 4'd1,  32'd3,          32'd5,          2'd0, 5'd0,  32'hFFFF_FFFE,  4'b1000});
        vecs.push_back('{"sub_ovf",    4'd1,  32'h8000_0000,  32'd1,          2'd0, 5'd0,  32'h7FFF_FFFF,  4'b0011});
        vecs.push_back('{"and",        4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  2'd0, 5'd0,  32'hF000_F000,  4'b1000});
        vecs.push_back('{"or",         4'd3,  32'h0F0F_0000,  32'h0000_00F0,  2'd0, 5'd0,  32'h0F0F_00F0,  4'b0000});
        vecs.push_back('{"xor",        4'd4,  32'hAAAA_5555,  32'hFFFF_0000,  2'd0, 5'd0,  32'h5555_5555,  4'b0000});
        vecs.push_back('{"slt_true",   4'd5,  32'hFFFF_FFFF,  32'd1,          2'd0, 5'd0,  32'd1,          4'b0000});
        vecs.push_back('{"slt_false",  4'd5,  32'd5,          32'hFFFF_FFFF,  2'd0, 5'd0,  32'd0,          4'b0100});
        vecs.push_back('{"asr4",       4'd6,  32'h8000_0000,  32'd0,          2'd2, 5'd4,  32'hF800_0000,  4'b1000});
        vecs.push_back('{"ror1",       4'd6,  32'h0000_0001,  32'd0,          2'd3, 5'd1,  32'h8000_0000,  4'b1000});
        vecs.push_back('{"lsl0",       4'd6,  32'h1234_5678,  32'd0,          2'd0, 5'd0,  32'h1234_5678,  4'b0000});
        vecs.push_back('{"ror0",       4'd6,  32'h1234_5678,  32'd0,          2'd3, 5'd0,  32'h1234_5678,  4'b0000});
        vecs.push_back('{"lsr31",      4'd6,  32'h8000_0000,  32'd0,          2'd1, 5'd31, 32'd1,          4'b0000});
        vecs.push_back('{"lsl31",      4'd6,  32'h0000_0003,  32'd0,          2'd0, 5'd31, 32'h8000_0000,  4'b1000});
        vecs.push_back('{"passb",      4'd7,  32'd0,          32'hDEAD_BEEF,  2'd0, 5'd0,  32'hDEAD_BEEF,  4'b1000});
        vecs.push_back('{"op15_add",   4'd15, 32'hFFFF_FFFF,  32'd2,          2'd0, 5'd0,  32'd1,          4'b0010});

        // reset state
        idle_inputs();
        rst = 0;
        #1;
        check("rst_validm", {31'd0, bus.ValidM}, 32'd0);
        check("rst_aluresm", bus.ALU_ResultM, 32'd0);
        check("rst_stall", {31'd0, bus.StallE}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        step();
        step();
        rst = 1;
        step();

        // table-driven single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].st,
                         vecs[i].amt, vecs[i].exp_res, vecs[i].exp_flags);
        end

        // ADD with forwarding: B from ALU_ResultM (0x10), A from ResultW
        apply_single("seed_passb", 4'd7, 32'd0, 32'h10, 2'd0, 5'd0, 32'h10, 4'b0000);
        idle_inputs();
        bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUControlE = 4'd0;
        bus.RD1_E = 32'h1234_5678; bus.ForwardA_E = 2'b01; bus.ResultW = 32'h8765_4321;
        bus.RD2_E = 32'hCAFE_0000; bus.ForwardB_E = 2'b10;
        bus.RD_E = 5'd9; bus.PCPlus4E = 32'h0000_2004; bus.ResultSrcE = 1;
        #1;
        check("fwd_nostall", {31'd0, bus.StallE}, 32'd0);
        step();
        check("fwd_res", bus.ALU_ResultM, 32'h8765_4331);
        check("fwd_wdata", bus.WriteDataM, 32'h10);
        check("fwd_validm", {31'd0, bus.ValidM}, 32'd1);
        check("fwd_rdm", {27'd0, bus.RD_M}, 32'd9);
        check("fwd_pc4m", bus.PCPlus4M, 32'h0000_2004);
        check("fwd_rsrcm", {31'd0, bus.ResultSrcM}, 32'd1);

        // branch on SUB zero, then the same branch flushed
        idle_inputs();
        bus.ValidE = 1; bus.ALUControlE = 4'd1; bus.RD1_E = 5; bus.RD2_E = 5;
        bus.BranchE = 1; bus.PCE = 32'h1000; bus.Imm_Ext_E = 32'h100;
        #1;
        check("br_flags", {28'd0, bus.ALUFlagsE}, 32'b0110);
        check("br_taken", {31'd0, bus.PCSrcE}, 32'd1);
        check("br_target", bus.PCTargetE, 32'h1100);
        bus.FlushE = 1; bus.MemWriteE = 1;
        #1;
        check("br_flush_nottaken", {31'd0, bus.PCSrcE}, 32'd0);
        step();
        check("flush_bubble_v", {31'd0, bus.ValidM}, 32'd0);
        check("flush_bubble_mw", {31'd0, bus.MemWriteM}, 32'd0);

        // ~ValidE bubble, then a store passes through
        idle_inputs();
        bus.RegWriteE = 1; bus.MemWriteE = 1;
        step();
        check("inv_bubble_rw", {31'd0, bus.RegWriteM}, 32'd0);
        check("inv_bubble_mw", {31'd0, bus.MemWriteM}, 32'd0);
        bus.ValidE = 1; bus.RegWriteE = 0;
        step();
        check("store_mw", {31'd0, bus.MemWriteM}, 32'd1);
        check("store_rw", {31'd0, bus.RegWriteM}, 32'd0);

        // multi-cycle corner cases
        run_mc("mul",      4'd8,  32'h0001_0003, 32'd5, 32'h0005_000F);
        run_mc("divu",     4'd9,  32'd100, 32'd7, 32'd14);
        run_mc("remu",     4'd10, 32'd100, 32'd7, 32'd2);
        run_mc("divu_z",   4'd9,  32'd9, 32'd0, 32'hFFFF_FFFF);
        run_mc("remu_z",   4'd10, 32'd9, 32'd0, 32'd9);
        run_mc("mul_wrap", 4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

        // flush at BUSY cycle 10
        idle_inputs();
        bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUControlE = 4'd9;
        bus.RD1_E = 32'd1000; bus.RD2_E = 32'd3;
        #1;
        step();                    // now BUSY cycle 0
        repeat (10) step();        // BUSY cycle 10
        bus.FlushE = 1;
        #1;
        step();
        bus.FlushE = 0; bus.ValidE = 0;
        #1;
        check("flush_stall_drop", {31'd0, bus.StallE}, 32'd0);
        check("flush_validm", {31'd0, bus.ValidM}, 32'd0);
        step();
        check("flush_validm2", {31'd0, bus.ValidM}, 32'd0);
        check("flush_stall_stays", {31'd0, bus.StallE}, 32'd0);

        // reset mid-DIVU
        idle_inputs();
        apply_single("pre_rst", 4'd0, 32'd40, 32'd2, 2'd0, 5'd0, 32'd42, 4'b0000);
        idle_inputs();
        bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUControlE = 4'd9;
        bus.RD1_E = 32'd77; bus.RD2_E = 32'd5; bus.RD_E = 5'd3; bus.PCPlus4E = 32'h44;
        #1;
        repeat (5) step();
        #2;
        rst = 0;
        #1;
        check("rst_mid_stall", {31'd0, bus.StallE}, 32'd0);
        check("rst_mid_validm", {31'd0, bus.ValidM}, 32'd0);
        check("rst_mid_aluresm", bus.ALU_ResultM, 32'd0);
        check("rst_mid_pc4m", bus.PCPlus4M, 32'd0);
        check("rst_mid_rdm", {27'd0, bus.RD_M}, 32'd0);
        check("rst_mid_state", {30'd0, fsm_state}, 32'd0);
        bus.ValidE = 0;
        step();
        rst = 1;
        step();
        apply_single("post_rst_add", 4'd0, 32'd7, 32'd8, 2'd0, 5'd0, 32'd15, 4'b0000);

        // randomized single-cycle ops against the model
        for (int i = 0; i < 40; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(11, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            st  = 2'($urandom_range(0, 3));
            amt = 5'($urandom_range(0, 31));
            r   = ref_result(op, a, b, st, amt);
            apply_single("rand_sc", op, a, b, st, amt, r, ref_flags(op, a, b, r));
        end

        // randomized multi-cycle ops against the model
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(8, 10));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_mc("rand_mc", op, a, b, ref_result(op, a, b, 2'd0, 5'd0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised next-generation execute stage for the pipelined CPU, sitting between the ID/EX and EX/MEM boundaries.
- Adds a configurable datapath width (XLEN) on top of the forwarding muxes, single-cycle ALU, shifter and branch resolution.
- Adds a 4-bit op space with iterative multi-cycle MUL/DIVU/REMU, a stall handshake to the hazard unit, a flush input, and a valid bit carried into the M stage.

Parameters:
- XLEN, 32, datapath width in bits (≥8, power of 2).
- SHW, $clog2(XLEN), shift-amount width.
- CW, $clog2(XLEN+1), iteration counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- ValidE  in  1  E-stage holds a real instruction.
- FlushE  in  1  kill the E-stage instruction.
- RegWriteE, MemWriteE, ResultSrcE, BranchE  in  1 each  control bits.
- ALUSrcE  in  1  0 = SrcB is forwarded RD2, 1 = SrcB is Imm_Ext_E.
- ALUControlE  in  4  op select (see Behaviour).
- ShiftTypeE  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- ShiftAmountE  in  SHW  shift distance.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands and PC values.
- RD_E  in  5  destination register.
- ResultW  in  XLEN  W-stage forward value.
- ForwardA_E, ForwardB_E  in  2 each  00 regfile, 01 ResultW, 10 ALU_ResultM, 11 regfile.
- StallE  out  1  multi-cycle op in progress; upstream must hold all E inputs.
- PCSrcE  out  1  branch taken.
- PCTargetE  out  XLEN  PCE + Imm_Ext_E, modulo 2^XLEN.
- ALUFlagsE  out  4  {N,Z,C,V} of the current E result.
- ValidM, RegWriteM, MemWriteM, ResultSrcM  out  1 each  EX/MEM control outputs.
- RD_M  out  5  EX/MEM destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each  EX/MEM data outputs.

Behaviour:
- Operands: SrcA = fwd(RD1_E, ForwardA_E); WriteData = fwd(RD2_E, ForwardB_E); SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
- Single-cycle ops (combinational result):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed compare; result is 1 or 0, zero-extended.
  - 0110 SHIFT: SrcA shifted by ShiftAmountE using ShiftTypeE. Amount 0 passes SrcA unchanged.
  - 0111 PASSB: result = SrcB.
  - Codes 1011–1111 behave as ADD.
- Flags:
  - N = result[XLEN-1]; Z = (result == 0).
  - C and V are defined for ADD/SUB only; SUB carry means no-borrow. C = V = 0 for all other ops.
  - PCSrcE = BranchE & ValidE & Z & ~FlushE & ~StallE.
- Multi-cycle ops: 1000 MUL (low XLEN bits of the product, shift-add), 1001 DIVU, 1010 REMU (restoring division, 1 bit per cycle).
- Multi-cycle FSM:
  - IDLE: on ValidE & mc-op & ~FlushE, latch SrcA/SrcB (this freezes the forwarded values), clear the counter, go to BUSY. StallE=1 in this cycle.
  - BUSY: one iteration per cycle with StallE=1. When counter == XLEN-1, go to DONE.
  - DONE: StallE=0; the result drives ALU_ResultM input; the EX/MEM register captures on this edge; return to IDLE.
  - Total occupancy is XLEN+2 cycles; StallE is high for XLEN+1 of them.
- Divide by zero: DIVU result is all ones, REMU result is the dividend. No trap.
- EX/MEM register:
  - On each clk edge, if ~StallE, capture the E-stage values.
  - If StallE or FlushE or ~ValidE, insert a bubble instead: ValidM=RegWriteM=MemWriteM=0. Data outputs still load, but their values are don't-care.
- FlushE in BUSY or DONE: abort to IDLE next cycle, StallE low next cycle, M receives a bubble.
- A new op presented in the DONE cycle is not accepted until IDLE; upstream keeps holding it because the hazard unit stalls one cycle on DONE→IDLE.
- Reset (rst=0, async):
  - FSM goes to IDLE, counter = 0.
  - All M outputs are 0.
  - StallE = 0.
  - Reset mid-operation discards the operation.

Test Plan (XLEN=32):
- ADD forwarding: RD1_E=0x12345678, ForwardA=01, ResultW=0x87654321, ForwardB=10, ALU_ResultM=0x00000010, ALU=ADD, ValidE=1 → next edge ALU_ResultM=0x87654331, ValidM=1, no stall.
- SUB flags: SrcA=SrcB=5, SUB → ALUFlagsE=0110 (Z,C). With BranchE=1 → PCSrcE=1 and PCTargetE=PCE+Imm (0x1000+0x100=0x1100).
- Shifts: ASR of 0x80000000 by 4 → 0xF8000000; ROR of 0x00000001 by 1 → 0x80000000; shift by 0 → SrcA unchanged.
- MUL: 0x0001_0003 × 0x0000_0005 → StallE high for 33 cycles with bubbles in M, then ALU_ResultM=0x0005_000F and ValidM=1.
- DIVU/REMU: 100/7 → 14 and 100%7 → 2. Divide by zero: DIVU(9,0)=0xFFFFFFFF, REMU(9,0)=9.
- Interrupts and reset:
  - FlushE at BUSY cycle 10 → StallE drops the next cycle and ValidM stays 0.
  - rst=0 mid-DIVU → all outputs 0 immediately; after release, a fresh ADD completes normally.
